wbuf_ctrl: RTL
==============

WBUF_CTRL -- requirements
Module: wbuf_ctrl

Interface
REQ-001 SHALL have the following ports, one per line (name  direction  width  meaning):
- clk  input  1  clock, rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a fill/shift sequence.
- num_cols  input  8  column count, sampled on accepted start.
- sram_base  input  16  first SRAM address, sampled on accepted start.
- sdram_base  input  16  first SDRAM address, sampled on accepted start.
- sram_req  output  1  SRAM read request.
- sram_addr  output  16  SRAM read address.
- sram_ack  input  1  SRAM data valid this cycle.
- sdram_req  output  1  SDRAM read request.
- sdram_addr  output  16  SDRAM read address.
- sdram_ack  input  1  SDRAM data valid this cycle.
- enable_cu  output  1  weight-buffer command strobe.
- mode  output  3  weight-buffer opcode: 001 load w1 (SRAM), 010 load w2 (SRAM), 011 load w3 (SDRAM), 100 load w4 (SDRAM), 101 shift 2->1 and 4->3.
- win_valid  output  1  buffer holds a complete window for the consumer.
- win_ready  input  1  consumer has taken the window.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle end-of-sequence pulse.
- err  output  1  sticky timeout flag; exists only under the configuration macro.

Function
REQ-002 SHALL implement states IDLE, LD1, LD3, LD2, LD4, WIN, SHIFT, FIN.
REQ-003 IDLE: start=1 latches num_cols, sram_base and sdram_base, and asserts busy from the next cycle; start is ignored in every other state.
REQ-004 Accepted start with num_cols<2 SHALL go to FIN with no memory request; done pulses 1 cycle after start.
REQ-005 Accepted start with num_cols>=2 SHALL go to LD1.
REQ-006 LD1/LD2 SHALL hold sram_req=1 and sram_addr at the current SRAM pointer until sram_ack=1; LD3/LD4 SHALL do the same with sdram_req, sdram_addr and sdram_ack.
REQ-007 In the ack cycle: enable_cu=1 combinationally with mode set to the state's opcode (LD1 001, LD2 010, LD3 011, LD4 100); the corresponding pointer increments by 1 at the next edge; the state advances (LD1->LD3, LD3->LD2, LD2->LD4, LD4->WIN).
REQ-008 Outside ack cycles and SHIFT, enable_cu=0 and mode=000.
REQ-009 WIN SHALL hold win_valid=1 until win_ready=1 is sampled, then decrement the remaining-window count (initial value num_cols-1) and go to SHIFT if the count after decrement is nonzero, else FIN.
REQ-010 SHIFT SHALL last exactly 1 cycle with enable_cu=1 and mode=101, then go to LD2.
REQ-011 FIN SHALL pulse done for 1 cycle, clear busy and return to IDLE.
REQ-012 Reads per sequence (num_cols>=2): num_cols SRAM and num_cols SDRAM; windows issued: num_cols-1.
REQ-013 Pointers SHALL wrap modulo 2^16 (0xFFFF+1 -> 0x0000).
REQ-014 req and ack arriving in the same cycle SHALL count as completion, giving single-cycle reads.
REQ-015 An ack arriving while the matching req is low SHALL be ignored.

Reset
REQ-016 nrst=0 SHALL immediately force state IDLE and clear pointers and counters.
REQ-017 nrst=0 SHALL drive all outputs to 0, including mode=000; mid-sequence reset aborts with no done pulse.
REQ-018 err SHALL clear only on reset.

Configuration
REQ-019 Macro WBUF_CTRL_TIMEOUT_EN defined: an 8-bit wait counter runs while sram_req or sdram_req is high and resets on ack; reaching 255 cycles without ack sets err=1 and returns to IDLE with no done pulse.
REQ-020 Macro WBUF_CTRL_TIMEOUT_EN undefined: no counter and no err port; the block waits indefinitely for ack.

Verification
REQ-021 num_cols=3, sram_base=0x0010, sdram_base=0x0200, acks tied high -> opcodes 001,011,010,100, WIN, 101,010,100, WIN, done; last sram_addr=0x0012, last sdram_addr=0x0202.
REQ-022 num_cols=1 -> done exactly 1 cycle after start; no req asserted.
REQ-023 sram_ack delayed 5 cycles in LD1 -> sram_req and sram_addr stable for 5 cycles; enable_cu only in the ack cycle.
REQ-024 win_ready held low 10 cycles -> win_valid held 10 cycles, no SHIFT; start pulsed meanwhile is ignored.
REQ-025 sram_base=0xFFFF, num_cols=2 -> addresses 0xFFFF then 0x0000.
REQ-026 nrst pulsed low in LD4 -> outputs 0 immediately, no done pulse; with WBUF_CTRL_TIMEOUT_EN, an ack withheld 255 cycles -> err=1, IDLE.

Source files
------------

// File: rtl/wbuf_ctrl.sv
// rtl/wbuf_ctrl.sv - weight-buffer fill/shift sequencer (optional timeout: WBUF_CTRL_TIMEOUT_EN)
module wbuf_ctrl (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [7:0]  num_cols,
    input  logic [15:0] sram_base,
    input  logic [15:0] sdram_base,
    output logic        sram_req,
    output logic [15:0] sram_addr,
    input  logic        sram_ack,
    output logic        sdram_req,
    output logic [15:0] sdram_addr,
    input  logic        sdram_ack,
    output logic        enable_cu,
    output logic [2:0]  mode,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        busy,
    output logic        done
`ifdef WBUF_CTRL_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD1   = 3'd1,
        LD3   = 3'd2,
        LD2   = 3'd3,
        LD4   = 3'd4,
        WIN   = 3'd5,
        SHIFT = 3'd6,
        FIN   = 3'd7
    } state_t;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_LD_W1 = 3'b001;
    localparam logic [2:0] OP_LD_W2 = 3'b010;
    localparam logic [2:0] OP_LD_W3 = 3'b011;
    localparam logic [2:0] OP_LD_W4 = 3'b100;
    localparam logic [2:0] OP_SHIFT = 3'b101;

    state_t      state_q, state_d;
    logic [15:0] sram_ptr_q, sram_ptr_d;
    logic [15:0] sdram_ptr_q, sdram_ptr_d;
    // Windows still to hand to the consumer in this sequence.
    logic [7:0]  win_cnt_q, win_cnt_d;
    logic [7:0]  win_cnt_dec;

`ifdef WBUF_CTRL_TIMEOUT_EN
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic        ack_hit;
`endif

    assign win_cnt_dec = win_cnt_q - 8'd1;

    // Next-state, pointer/counter updates and decoded outputs; ack only counts while its req is high.
    always_comb begin
        state_d     = state_q;
        sram_ptr_d  = sram_ptr_q;
        sdram_ptr_d = sdram_ptr_q;
        win_cnt_d   = win_cnt_q;
        sram_req    = 1'b0;
        sram_addr   = 16'h0000;
        sdram_req   = 1'b0;
        sdram_addr  = 16'h0000;
        enable_cu   = 1'b0;
        mode        = OP_NONE;
        win_valid   = 1'b0;
        busy        = (state_q != IDLE);
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sram_ptr_d  = sram_base;
                    sdram_ptr_d = sdram_base;
                    win_cnt_d   = num_cols - 8'd1;
                    state_d     = (num_cols < 8'd2) ? FIN : LD1;
                end
            end
            LD1: begin
                sram_req  = 1'b1;
                sram_addr = sram_ptr_q;
                if (sram_ack) begin
                    enable_cu  = 1'b1;
                    mode       = OP_LD_W1;
                    sram_ptr_d = sram_ptr_q + 16'd1;
                    state_d    = LD3;
                end
            end
            LD3: begin
                sdram_req  = 1'b1;
                sdram_addr = sdram_ptr_q;
                if (sdram_ack) begin
                    enable_cu   = 1'b1;
                    mode        = OP_LD_W3;
                    sdram_ptr_d = sdram_ptr_q + 16'd1;
                    state_d     = LD2;
                end
            end
            LD2: begin
                sram_req  = 1'b1;
                sram_addr = sram_ptr_q;
                if (sram_ack) begin
                    enable_cu  = 1'b1;
                    mode       = OP_LD_W2;
                    sram_ptr_d = sram_ptr_q + 16'd1;
                    state_d    = LD4;
                end
            end
            LD4: begin
                sdram_req  = 1'b1;
                sdram_addr = sdram_ptr_q;
                if (sdram_ack) begin
                    enable_cu   = 1'b1;
                    mode        = OP_LD_W4;
                    sdram_ptr_d = sdram_ptr_q + 16'd1;
                    state_d     = WIN;
                end
            end
            WIN: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    win_cnt_d = win_cnt_dec;
                    state_d   = (win_cnt_dec != 8'd0) ? SHIFT : FIN;
                end
            end
            SHIFT: begin
                enable_cu = 1'b1;
                mode      = OP_SHIFT;
                state_d   = LD2;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef WBUF_CTRL_TIMEOUT_EN
        ack_hit = (sram_req & sram_ack) | (sdram_req & sdram_ack);
        wait_d  = 8'd0;
        err_d   = err_q;
        if ((sram_req || sdram_req) && !ack_hit) begin
            if (wait_q == 8'd254) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
`endif
    end

`ifdef WBUF_CTRL_TIMEOUT_EN
    assign err = err_q;

    // Wait counter and sticky timeout flag; err only clears on reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wait_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end
`endif

    // State, address pointers and window counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            sram_ptr_q  <= 16'h0000;
            sdram_ptr_q <= 16'h0000;
            win_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            sram_ptr_q  <= sram_ptr_d;
            sdram_ptr_q <= sdram_ptr_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

endmodule
